ifftshift_reorder: RTL and testbench
====================================

IFFTSHIFT_REORDER -- requirements
Module: ifftshift_reorder

Interface
REQ-001 The block SHALL have parameter DW, default 16, giving the sample width in bits.
REQ-002 The block SHALL have parameter AW, default 11, giving the buffer address width; the buffer depth is 2^AW = 2048.
REQ-003 clk  input  1  the only clock; all logic samples on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  an input sample is present.
REQ-006 in_data  input  DW  input sample.
REQ-007 in_last  input  1  marks the final sample of the input frame.
REQ-008 in_ready  output  1  the block accepts an input sample this cycle.
REQ-009 out_valid  output  1  an output sample is present.
REQ-010 out_data  output  DW  output sample, registered.
REQ-011 out_last  output  1  marks the final sample of the output frame.
REQ-012 out_ready  input  1  the downstream block accepts the output sample.
REQ-013 frame_len  output  AW+1  length N of the last frame captured; held until the next capture completes.
REQ-014 busy  output  1  high in the WRITE and READ states.

Function
REQ-015 The block SHALL implement the inverse of the fftshift reorder: for a frame x[0..N-1], out[k] = x[(k + floor(N/2)) mod N], for k = 0..N-1.
REQ-016 The state machine SHALL have three states: IDLE, WRITE and READ.
- IDLE to WRITE on the first accepted sample that does not have in_last set.
- IDLE or WRITE to READ on the accepted sample that has in_last set.
- READ to IDLE on the output handshake where out_last is set.
REQ-017 A sample SHALL be accepted only when in_valid and in_ready are both high; in_ready SHALL equal (state != READ).
REQ-018 Accepted samples SHALL be written to an inferred AWx DW single-clock RAM at addresses 0, 1, 2, ... in arrival order.
REQ-019 When the 2048th sample is accepted without in_last, the block SHALL treat it as last, set N = 2048 and enter READ.
REQ-020 N SHALL equal the number of samples accepted; frame_len SHALL update in the same cycle the block enters READ.
REQ-021 The read address SHALL start at floor(N/2).
- It SHALL increment by 1 on each issued read.
- It SHALL wrap to 0 after N-1.
- Use a compare against N, not a power-of-two wrap.
- Exactly N reads SHALL be issued per frame.
REQ-022 The RAM read latency SHALL be 1 cycle. A new read SHALL be issued only when the output register is empty, or is being consumed in that cycle.
REQ-023 Latency: if the last input sample is accepted in cycle T, out_valid SHALL rise in cycle T+2.
REQ-024 With out_ready held high, the block SHALL output one sample per cycle with no gaps, and out_last SHALL be high on the Nth sample only.
REQ-025 While out_valid is high and out_ready is low, out_data, out_last and out_valid SHALL hold stable; no sample SHALL be lost or duplicated.
REQ-026 For N = 1, the block SHALL output x[0] alone, with out_last high.
REQ-027 For odd N, the start index floor(N/2) SHALL use truncation. Example: N = 5 gives the read order 2, 3, 4, 0, 1.
REQ-028 After the out_last handshake in cycle U, in_ready SHALL be high in cycle U+1.
REQ-029 Input samples presented during READ SHALL be ignored (in_ready is low), and the current output frame SHALL be unaffected.

Reset
REQ-030 When rst is high at a clock edge, the block SHALL enter IDLE and clear the write counter, the read counter and the read count.
REQ-031 After reset, out_valid = 0, out_last = 0, out_data = 0, frame_len = 0, busy = 0 and in_ready = 1.
REQ-032 Reset asserted mid-WRITE or mid-READ SHALL abort the frame with no further output. RAM contents need not be cleared.

Verification
REQ-033 Even frame: N = 8, inputs 0..7, out_ready = 1 -> outputs 4, 5, 6, 7, 0, 1, 2, 3; out_last on the output 3; first out_valid 2 cycles after in_last is accepted; frame_len = 8.
REQ-034 Odd frame: N = 5, inputs 10..14 -> outputs 12, 13, 14, 10, 11; out_last on the output 11; frame_len = 5.
REQ-035 Backpressure: N = 6, out_ready toggled in a pseudo-random pattern -> outputs 3, 4, 5, 0, 1, 2 exactly once each; out_data is stable while stalled.
REQ-036 Full depth and length 1:
- 2048 samples with no in_last -> READ is forced, frame_len = 2048, first output is x[1024].
- N = 1 -> a single output with out_last high.
REQ-037 Reset mid-READ: rst asserted after 2 of 8 outputs -> out_valid = 0 the next cycle, in_ready = 1, and a new frame processes correctly.
REQ-038 Back-to-back frames: a second frame presented during READ -> in_ready stays 0 until the cycle after out_last, then the second frame is captured and reordered correctly.

Source files
------------

// File: rtl/ifftshift_reorder_if.sv
// rtl/ifftshift_reorder_if.sv - sample stream handshake bundle for the ifftshift reorder block
interface ifftshift_reorder_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/ifftshift_reorder.sv
// rtl/ifftshift_reorder.sv - captures a frame into RAM and replays it rotated by floor(N/2)
module ifftshift_reorder #(
    parameter int DW = 16,
    parameter int AW = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    ifftshift_reorder_if.slave   s,
    output logic [AW:0]          frame_len,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t        state, state_next;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW:0]   wr_cnt, wr_cnt_inc, n_len, rd_cnt;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] out_data_q;
    logic          out_valid_q, out_last_q;
    logic          accept, capture_done, issue, out_fire, rd_addr_end;

    always_comb begin
        state_next   = state;
        wr_cnt_inc   = wr_cnt + 1'b1;
        accept       = s.in_valid && (state != READ);
        capture_done = accept && (s.in_last || (wr_cnt_inc == DEPTH));
        out_fire     = out_valid_q && s.out_ready;
        // The RAM output register doubles as the output stage, so a read may
        // only be issued when that register is free or draining this cycle.
        issue        = (state == READ) && (rd_cnt != n_len) && (!out_valid_q || s.out_ready);
        rd_addr_end  = ({1'b0, rd_addr} == (n_len - 1'b1));
        case (state)
            IDLE, WRITE: begin
                if (capture_done)
                    state_next = READ;
                else if (accept)
                    state_next = WRITE;
            end
            READ: begin
                if (out_fire && out_last_q)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_cnt[AW-1:0]] <= s.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            rd_addr     <= '0;
            n_len       <= '0;
            frame_len   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (capture_done) begin
                wr_cnt    <= '0;
                n_len     <= wr_cnt_inc;
                frame_len <= wr_cnt_inc;
                rd_addr   <= wr_cnt_inc[AW:1];
                rd_cnt    <= '0;
            end else if (accept) begin
                wr_cnt <= wr_cnt_inc;
            end

            if (issue) begin
                out_data_q  <= mem[rd_addr];
                out_valid_q <= 1'b1;
                out_last_q  <= (rd_cnt == (n_len - 1'b1));
                rd_cnt      <= rd_cnt + 1'b1;
                rd_addr     <= rd_addr_end ? '0 : rd_addr + 1'b1;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign s.in_ready  = (state != READ);
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;
    assign busy        = (state != IDLE);
endmodule

// File: tb/tb_ifftshift_reorder.sv
// tb/tb_ifftshift_reorder.sv - directed self-checking bench for ifftshift_reorder
module tb_ifftshift_reorder;
    localparam int DW = 16;
    localparam int AW = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic [AW:0] frame_len;
    logic        busy;
    int          errors = 0;
    int          checks = 0;
    int          vin[$];
    int          vexp[$];
    int          fw, sp;

    ifftshift_reorder_if #(.DW(DW)) bus ();

    ifftshift_reorder #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (bus),
        .frame_len (frame_len),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int vals[$], input bit mark_last);
        foreach (vals[i]) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(vals[i]);
            bus.in_last  = mark_last && (i == vals.size() - 1);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Consumes up to 'take' outputs with out_ready following 'pat', checking
    // order, out_last placement and hold-steady behaviour while stalled.
    task automatic collect(input int exp[$], input int take, input logic [15:0] pat,
                           output int first_wait, output int span);
        int            idx;
        int            cyc;
        bit            stalled;
        logic [DW-1:0] held_d;
        logic          held_l;
        idx = 0; cyc = 0; stalled = 0; held_d = '0; held_l = 1'b0;
        first_wait = -1; span = 0;
        while (idx < take && cyc < 3 * exp.size() + 40) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, held_d);
                check("stall_last", bus.out_last, held_l);
            end
            check("in_ready_during_read", bus.in_ready, 0);
            bus.out_ready = pat[cyc % 16];
            if (bus.out_valid && first_wait < 0)
                first_wait = cyc;
            if (bus.out_valid && bus.out_ready) begin
                check("out_data", bus.out_data, exp[idx]);
                check("out_last", bus.out_last, (idx == exp.size() - 1));
                idx++;
                span = cyc - first_wait + 1;
                stalled = 0;
            end else begin
                stalled = bus.out_valid;
                held_d  = bus.out_data;
                held_l  = bus.out_last;
            end
        end
        if (idx < take)
            check("collect_timeout", idx, take);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_frame_len", frame_len, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;

        // Even frame, N = 8
        vin = '{0, 1, 2, 3, 4, 5, 6, 7};
        send(vin, 1'b1);
        check("even_valid_t1", bus.out_valid, 0);
        check("even_busy", busy, 1);
        check("even_in_ready", bus.in_ready, 0);
        check("even_frame_len", frame_len, 8);
        vexp = '{4, 5, 6, 7, 0, 1, 2, 3};
        collect(vexp, 8, 16'hFFFF, fw, sp);
        check("even_latency", fw, 1);
        check("even_no_gaps", sp, 8);
        @(negedge clk);
        check("even_ready_after_last", bus.in_ready, 1);
        check("even_idle_busy", busy, 0);
        check("even_idle_valid", bus.out_valid, 0);

        // Reset after two outputs of an eight-sample frame
        vin = '{30, 31, 32, 33, 34, 35, 36, 37};
        send(vin, 1'b1);
        vexp = '{34, 35, 36, 37, 30, 31, 32, 33};
        collect(vexp, 2, 16'hFFFF, fw, sp);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_frame_len", frame_len, 0);
        @(negedge clk);
        check("midrst_no_output", bus.out_valid, 0);

        // Odd frame, N = 5
        vin = '{10, 11, 12, 13, 14};
        send(vin, 1'b1);
        check("odd_frame_len", frame_len, 5);
        vexp = '{12, 13, 14, 10, 11};
        collect(vexp, 5, 16'hFFFF, fw, sp);
        check("odd_no_gaps", sp, 5);
        @(negedge clk);

        // Backpressure, N = 6
        vin = '{0, 1, 2, 3, 4, 5};
        send(vin, 1'b1);
        check("bp_frame_len", frame_len, 6);
        vexp = '{3, 4, 5, 0, 1, 2};
        collect(vexp, 6, 16'b0110_1001_1100_1010, fw, sp);
        @(negedge clk);
        check("bp_ready_after", bus.in_ready, 1);

        // Single-sample frame
        vin = '{42};
        send(vin, 1'b1);
        check("n1_frame_len", frame_len, 1);
        vexp = '{42};
        collect(vexp, 1, 16'hFFFF, fw, sp);
        check("n1_latency", fw, 1);
        @(negedge clk);
        check("n1_ready_after", bus.in_ready, 1);

        // Full depth without in_last forces READ
        vin.delete();
        for (int i = 0; i < 2048; i++)
            vin.push_back(i * 3 + 7);
        send(vin, 1'b0);
        check("full_frame_len", frame_len, 2048);
        check("full_in_ready", bus.in_ready, 0);
        check("full_busy", busy, 1);
        vexp.delete();
        for (int k = 0; k < 2048; k++)
            vexp.push_back(vin[(k + 1024) % 2048]);
        collect(vexp, 2048, 16'hFFFF, fw, sp);
        check("full_no_gaps", sp, 2048);
        @(negedge clk);
        check("full_ready_after", bus.in_ready, 1);

        // Back-to-back: next frame's first sample held during READ
        vin = '{50, 51, 52, 53};
        send(vin, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(20);
        bus.in_last  = 1'b0;
        vexp = '{52, 53, 50, 51};
        collect(vexp, 4, 16'hFFFF, fw, sp);
        @(negedge clk);
        check("b2b_ready_after_last", bus.in_ready, 1);
        vin = '{21, 22, 23};
        send(vin, 1'b1);
        check("b2b_frame_len", frame_len, 4);
        vexp = '{22, 23, 20, 21};
        collect(vexp, 4, 16'hFFFF, fw, sp);
        @(negedge clk);
        check("b2b_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
